mem_wb_stage: RTL

- MEM/WB pipeline register with load-data extraction, sitting between data memory and the write-back data mux (JAL / PC+8 select).
- Each advancing cycle it registers:
  - the load-extracted memory word or the ALU result,
  - PC+8, the JAL flag, the register-write enable and the destination address.
- Also provides a sticky halt freeze and a misaligned-load fault flag for the debug unit.

---
 rtl/mem_wb_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register. Extracts the load lane from the aligned memory
// word, then registers write-back data, PC+8, the JAL flag, the write enable
// and the destination register. Also keeps a sticky halt freeze, a sticky
// misaligned-load flag and a retired write-back counter.
module mem_wb_stage #(
  parameter int BITS_SIZE     = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int CNT_BITS      = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_flush,
  input  logic                     i_halt,
  input  logic                     i_reg_write,
  input  logic                     i_mem_to_reg,
  input  logic                     i_jal,
  input  logic [1:0]               i_load_size,
  input  logic                     i_load_unsigned,
  input  logic [BITS_SIZE-1:0]     i_alu_result,
  input  logic [BITS_SIZE-1:0]     i_mem_data,
  input  logic [BITS_SIZE-1:0]     i_pc8,
  input  logic [REG_ADDR_BITS-1:0] i_rd_addr,
  output logic [BITS_SIZE-1:0]     o_data_write,
  output logic [BITS_SIZE-1:0]     o_pc8,
  output logic                     o_jal,
  output logic                     o_reg_write,
  output logic [REG_ADDR_BITS-1:0] o_rd_addr,
  output logic                     o_halt,
  output logic                     o_load_fault,
  output logic [CNT_BITS-1:0]      o_retired
);

  logic [1:0]           off;
  logic [7:0]           byte_lane;
  logic [15:0]          half_lane;
  logic [BITS_SIZE-1:0] ext_data;
  logic [BITS_SIZE-1:0] cap_data;
  logic                 misaligned;
  logic                 cap_reg_write;
  logic                 update;

  assign off = i_alu_result[1:0];

  // Little-endian lane select and sign/zero extension of the loaded value.
  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    ext_data  = i_mem_data;
    case (off)
      2'd0:    byte_lane = i_mem_data[7:0];
      2'd1:    byte_lane = i_mem_data[15:8];
      2'd2:    byte_lane = i_mem_data[23:16];
      default: byte_lane = i_mem_data[31:24];
    endcase
    half_lane = off[1] ? i_mem_data[31:16] : i_mem_data[15:0];
    case (i_load_size)
      2'b00: ext_data = i_load_unsigned ? {{(BITS_SIZE-8){1'b0}}, byte_lane}
                                        : {{(BITS_SIZE-8){byte_lane[7]}}, byte_lane};
      2'b01: ext_data = i_load_unsigned ? {{(BITS_SIZE-16){1'b0}}, half_lane}
                                        : {{(BITS_SIZE-16){half_lane[15]}}, half_lane};
      default: ext_data = i_mem_data;
    endcase
  end

  // Misalignment only matters for loads; a faulting load never writes back.
  always_comb begin
    misaligned = 1'b0;
    if (i_mem_to_reg) begin
      case (i_load_size)
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = off[0];
        default: misaligned = (off != 2'd0);
      endcase
    end
  end

  assign cap_data      = i_mem_to_reg ? ext_data : i_alu_result;
  assign cap_reg_write = i_reg_write & ~misaligned;
  assign update        = i_enable & ~o_halt;

  // Pipeline register: reset first, then enabled edges capture a bubble or the
  // instruction; once halted the stage freezes until reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_data_write <= '0;
      o_pc8        <= '0;
      o_jal        <= 1'b0;
      o_reg_write  <= 1'b0;
      o_rd_addr    <= '0;
      o_halt       <= 1'b0;
      o_load_fault <= 1'b0;
      o_retired    <= '0;
    end else if (update) begin
      if (i_flush) begin
        o_data_write <= '0;
        o_pc8        <= '0;
        o_jal        <= 1'b0;
        o_reg_write  <= 1'b0;
        o_rd_addr    <= '0;
      end else begin
        o_data_write <= cap_data;
        o_pc8        <= i_pc8;
        o_jal        <= i_jal;
        o_reg_write  <= cap_reg_write;
        o_rd_addr    <= i_rd_addr;
        o_halt       <= i_halt;
        o_load_fault <= o_load_fault | misaligned;
        o_retired    <= o_retired + {{(CNT_BITS-1){1'b0}}, cap_reg_write};
      end
    end
  end

endmodule
